hicore_mem_arb: RTL

HICORE_MEM_ARB -- requirements
Module: hicore_mem_arb

---
 rtl/hicore_mem_arb.sv | 113 +++++++++++
 1 files changed

// File: rtl/hicore_mem_arb.sv
// Round-robin N-way arbiter feeding one registered output stage; a multi-beat
// burst (last=0) locks the grant to its owner until the closing last beat.
module hicore_mem_arb #(
  parameter int N  = 2,
  parameter int DW = 32,
  parameter int IW = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req_vld,
  output logic [N-1:0]    req_rdy,
  input  logic [N*DW-1:0] req_dat,
  input  logic [N-1:0]    req_last,
  output logic            o_vld,
  input  logic            o_rdy,
  output logic [DW-1:0]   o_dat,
  output logic [IW-1:0]   o_id,
  output logic            o_last,
  input  logic            flush
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

  state_t          r_state;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_lock_id;
  logic            r_vld;
  logic [DW-1:0]   r_dat;
  logic [IW-1:0]   r_id;
  logic            r_last;

  logic [N-1:0]    w_hi_mask;
  logic [N-1:0]    w_search;
  logic [IW-1:0]   w_pick;
  logic [IW-1:0]   w_grant;
  logic            w_take;
  logic            w_sel_vld;
  logic            w_sel_last;
  logic [DW-1:0]   w_sel_dat;
  logic            w_accept;
  logic [IW-1:0]   w_ptr_nxt;

  // Grant selection: requesters at or above ptr win first, then wrap to the lowest index.
  always_comb begin
    w_hi_mask = '0;
    for (int k = 0; k < N; k++) begin
      w_hi_mask[k] = (IW'(k) >= r_ptr);
    end
    w_search = (|(req_vld & w_hi_mask)) ? (req_vld & w_hi_mask) : req_vld;
    w_pick   = r_ptr;
    for (int k = N - 1; k >= 0; k--) begin
      w_pick = w_search[k] ? IW'(k) : w_pick;
    end
    case (r_state)
      ST_IDLE:   w_grant = w_pick;
      ST_LOCKED: w_grant = r_lock_id;
      default:   w_grant = r_ptr;
    endcase
  end

  // Steer the granted requester's payload and ready; readiness ignores req_vld.
  always_comb begin
    w_take     = (~r_vld | o_rdy) & ~flush;
    w_sel_vld  = 1'b0;
    w_sel_last = 1'b0;
    w_sel_dat  = '0;
    req_rdy    = '0;
    for (int k = 0; k < N; k++) begin
      w_sel_vld  = w_sel_vld  | ((w_grant == IW'(k)) & req_vld[k]);
      w_sel_last = w_sel_last | ((w_grant == IW'(k)) & req_last[k]);
      w_sel_dat  = w_sel_dat  | ({DW{w_grant == IW'(k)}} & req_dat[k*DW +: DW]);
      req_rdy[k] = (w_grant == IW'(k)) & w_take;
    end
    w_accept  = w_sel_vld & w_take;
    w_ptr_nxt = (w_grant == IW'(N - 1)) ? '0 : (w_grant + IW'(1));
  end

  // Lock/pointer FSM and output stage; flush outranks accept and drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_lock_id <= '0;
      r_vld     <= 1'b0;
      r_dat     <= '0;
      r_id      <= '0;
      r_last    <= 1'b0;
    end else if (flush) begin
      r_vld   <= 1'b0;
      r_state <= ST_IDLE;
    end else if (w_accept) begin
      r_vld  <= 1'b1;
      r_dat  <= w_sel_dat;
      r_id   <= w_grant;
      r_last <= w_sel_last;
      if (w_sel_last) begin
        r_state <= ST_IDLE;
        r_ptr   <= w_ptr_nxt;
      end else begin
        r_state   <= ST_LOCKED;
        r_lock_id <= w_grant;
      end
    end else if (o_rdy) begin
      r_vld <= 1'b0;
    end
  end

  assign o_vld  = r_vld;
  assign o_dat  = r_dat;
  assign o_id   = r_id;
  assign o_last = r_last;

endmodule
